// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory handshake, control-stage redirect/stall
// inputs and the registered instruction/PC pair presented to decode.
// master: the fetch controller. slave: the surrounding memory/core environment.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_misaligned;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_misaligned,
        input  imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_misaligned,
        output imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the program counter, issues one imem request
// at a time, presents a registered instruction/PC pair to decode and applies
// branch/jump redirects, squashing a response that is still in flight.
// Optional feature macro: MISALIGN_TRAP_EN -- a redirect to a non-word-aligned
// target fetches from TRAP_VEC and pulses fetch_misaligned for one cycle.
// Without it, target bits [1:0] are dropped and fetch_misaligned is held at 0.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
   ,parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
`endif
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] fetch_pc_r;
    logic        kill_r;
    logic        imem_req_r;
    logic        if_valid_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_instr_r;
    logic [31:0] redirect_tgt_s;

    // Word-align a byte address by dropping its two low bits.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic redirect_bad_s;
    logic misaligned_r;

    // Select the redirect fetch address; a misaligned target diverts to the trap vector.
    always_comb begin
        redirect_bad_s = (bus.redirect_pc[1:0] != 2'b00);
        if (redirect_bad_s) begin
            redirect_tgt_s = TRAP_VEC;
        end else begin
            redirect_tgt_s = bus.redirect_pc;
        end
    end

    // One-cycle flag for a redirect whose target was not word aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_r <= 1'b0;
        end else begin
            misaligned_r <= bus.redirect & redirect_bad_s;
        end
    end

    assign bus.fetch_misaligned = misaligned_r;
`else
    // Select the redirect fetch address; low bits are silently dropped.
    always_comb begin
        redirect_tgt_s = align_pc(bus.redirect_pc);
    end

    assign bus.fetch_misaligned = 1'b0;
`endif

    // Fetch FSM: state, program counter, squash flag and registered decode outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_VEC;
            kill_r     <= 1'b0;
            imem_req_r <= 1'b0;
            if_valid_r <= 1'b0;
            if_pc_r    <= 32'h0000_0000;
            if_instr_r <= 32'h0000_0000;
        end else if (bus.redirect) begin
            // Redirect beats stall and every other event; the last target wins.
            fetch_pc_r <= redirect_tgt_s;
            if_valid_r <= 1'b0;
            case (state_r)
                ST_REQ: begin
                    if (bus.imem_gnt) begin
                        // Old-address request already accepted: squash its response.
                        state_r    <= ST_WAIT;
                        kill_r     <= 1'b1;
                        imem_req_r <= 1'b0;
                    end else begin
                        state_r    <= ST_REQ;
                        imem_req_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        // Response arrives now and is dropped; nothing left in flight.
                        state_r    <= ST_REQ;
                        kill_r     <= 1'b0;
                        imem_req_r <= 1'b1;
                    end else begin
                        state_r    <= ST_WAIT;
                        kill_r     <= 1'b1;
                        imem_req_r <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and OUT have nothing outstanding: refetch directly.
                    state_r    <= ST_REQ;
                    imem_req_r <= 1'b1;
                end
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_REQ;
                    imem_req_r <= 1'b1;
                end
                ST_REQ: begin
                    if (bus.imem_gnt) begin
                        state_r    <= ST_WAIT;
                        imem_req_r <= 1'b0;
                    end else begin
                        state_r    <= ST_REQ;
                        imem_req_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (kill_r) begin
                            state_r    <= ST_REQ;
                            kill_r     <= 1'b0;
                            imem_req_r <= 1'b1;
                        end else begin
                            if_instr_r <= bus.imem_rdata;
                            if_pc_r    <= fetch_pc_r;
                            if_valid_r <= 1'b1;
                            fetch_pc_r <= fetch_pc_r + 32'd4;
                            state_r    <= ST_OUT;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_OUT: begin
                    if (!bus.stall) begin
                        if_valid_r <= 1'b0;
                        state_r    <= ST_REQ;
                        imem_req_r <= 1'b1;
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    kill_r     <= 1'b0;
                    imem_req_r <= 1'b0;
                    if_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_r;
    assign bus.imem_addr = fetch_pc_r;
    assign bus.if_valid  = if_valid_r;
    assign bus.if_pc     = if_pc_r;
    assign bus.if_instr  = if_instr_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: fetch sequencing, stall hold, redirect squash
// in WAIT and at grant, PC wrap, misaligned redirect and mid-transaction reset.
module tb_fetch_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    fetch_if bus ();

    fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From REQ: grant at once, respond next cycle, land in OUT with the word presented.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        check("fetch_req", {31'd0, bus.imem_req}, 32'd1);
        check("fetch_addr", bus.imem_addr, addr);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        check("wait_req_low", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0000_0000;
        check("out_valid", {31'd0, bus.if_valid}, 32'd1);
        check("out_pc", bus.if_pc, addr);
        check("out_instr", bus.if_instr, data);
    endtask

    initial begin
        logic exp_mis;
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0000_0000;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif

        // Reset state
        step();
        step();
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0000_0000);
        check("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_pc", bus.if_pc, 32'h0000_0000);
        check("rst_instr", bus.if_instr, 32'h0000_0000);
        check("rst_mis", {31'd0, bus.fetch_misaligned}, 32'd0);
        rst = 1'b0;
        step();

        // 1: two sequential fetches, 3-cycle spacing
        fetch_one(32'h0000_0000, 32'h0000_0013);
        step();
        check("t1_consumed", {31'd0, bus.if_valid}, 32'd0);
        fetch_one(32'h0000_0004, 32'h0050_0093);
        step();

        // 2: stall holds the presented instruction for 5 cycles
        fetch_one(32'h0000_0008, 32'h00A0_0113);
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_valid", {31'd0, bus.if_valid}, 32'd1);
            check("t2_pc", bus.if_pc, 32'h0000_0008);
            check("t2_instr", bus.if_instr, 32'h00A0_0113);
            check("t2_req", {31'd0, bus.imem_req}, 32'd0);
        end
        bus.stall = 1'b0;
        step();
        check("t2_next_req", {31'd0, bus.imem_req}, 32'd1);
        check("t2_next_addr", bus.imem_addr, 32'h0000_000C);

        // 3: redirect in WAIT, squashed response two cycles later
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        step();
        bus.redirect = 1'b0;
        check("t3_wait_req", {31'd0, bus.imem_req}, 32'd0);
        check("t3_mis", {31'd0, bus.fetch_misaligned}, 32'd0);
        step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        step();
        bus.imem_rvalid = 1'b0;
        check("t3_squash_valid", {31'd0, bus.if_valid}, 32'd0);
        check("t3_squash_instr", bus.if_instr, 32'h00A0_0113);
        fetch_one(32'h0000_0040, 32'h1111_1111);
        step();

        // 4: redirect coincident with grant for address 16
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0010;
        step();
        check("t4_addr16", bus.imem_addr, 32'h0000_0010);
        bus.redirect_pc = 32'h0000_0080;
        bus.imem_gnt    = 1'b1;
        step();
        bus.redirect = 1'b0;
        bus.imem_gnt = 1'b0;
        check("t4_wait_req", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        step();
        bus.imem_rvalid = 1'b0;
        check("t4_squash_valid", {31'd0, bus.if_valid}, 32'd0);
        fetch_one(32'h0000_0080, 32'h2222_2222);
        step();

        // 5: PC wraps modulo 2^32
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        fetch_one(32'hFFFF_FFFC, 32'h3333_3333);
        step();
        check("t5_wrap_addr", bus.imem_addr, 32'h0000_0000);

        // Redirect under stall in OUT still drops the instruction and refetches
        fetch_one(32'h0000_0000, 32'h4444_4444);
        bus.stall       = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        step();
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        check("rs_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rs_req", {31'd0, bus.imem_req}, 32'd1);
        check("rs_addr", bus.imem_addr, 32'h0000_0200);

        // 6: misaligned redirect, then reset in the middle of WAIT
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        step();
        bus.redirect = 1'b0;
        check("t6_addr", bus.imem_addr, 32'h0000_0100);
        check("t6_mis_pulse", {31'd0, bus.fetch_misaligned}, {31'd0, exp_mis});
        step();
        check("t6_mis_clear", {31'd0, bus.fetch_misaligned}, 32'd0);
        check("t6_req_hold", {31'd0, bus.imem_req}, 32'd1);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        check("t6_in_wait", {31'd0, bus.imem_req}, 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("t6_rst_addr", bus.imem_addr, 32'h0000_0000);
        check("t6_rst_valid", {31'd0, bus.if_valid}, 32'd0);
        check("t6_rst_pc", bus.if_pc, 32'h0000_0000);
        check("t6_rst_instr", bus.if_instr, 32'h0000_0000);
        check("t6_rst_mis", {31'd0, bus.fetch_misaligned}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("t6_post_req", {31'd0, bus.imem_req}, 32'd1);
        check("t6_post_addr", bus.imem_addr, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
